// File: rtl/arm_mem_pkg.sv
// Shared types for the SRAM port arbiter: FSM states, owner encoding and default widths.
// The wait counter is also intended for reuse by the cache controller.
package arm_mem_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [2:0] {
    IDLE,
    ACC_MEM,
    ACC_IF,
    DONE_MEM,
    DONE_IF
  } arb_state_t;

  // Which pipeline stage currently owns the SRAM port
  localparam logic OWNER_MEM = 1'b0;
  localparam logic OWNER_IF  = 1'b1;

endpackage

// File: rtl/wait_counter.sv
// Loadable 4-bit down-counter with a zero flag; holds at zero once it gets there.
module wait_counter
  import arm_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported SRAM between instruction fetch and load/store,
// sequencing each access through a fixed number of wait cycles.
module mem_port_arbiter
  import arm_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              freeze_if,
  output logic              freeze_mem,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_we,
  output logic              sram_oe,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

  arb_state_t state, state_next;
  logic       cnt_load;
  logic       cnt_dec;
  logic       cnt_zero;
  logic       mem_req;
  logic       grant_owner;

  assign mem_req    = mem_rd | mem_wr;
  assign freeze_if  = if_req & ~if_ready;
  assign freeze_mem = mem_req & ~mem_ready;

  wait_counter u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (LOAD_VAL),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // MEM wins ties: it carries the older instruction in the pipeline
  always_comb begin
    state_next  = state;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    grant_owner = mem_req ? OWNER_MEM : OWNER_IF;
    unique case (state)
      IDLE: begin
        if (mem_req || if_req) begin
          state_next = (grant_owner == OWNER_MEM) ? ACC_MEM : ACC_IF;
          cnt_load   = 1'b1;
        end
      end
      ACC_MEM: begin
        if (cnt_zero) state_next = DONE_MEM;
        else          cnt_dec    = 1'b1;
      end
      ACC_IF: begin
        if (cnt_zero) state_next = DONE_IF;
        else          cnt_dec    = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_we    <= 1'b0;
      sram_oe    <= 1'b0;
      if_ready   <= 1'b0;
      mem_ready  <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
    end else begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      if ((state == IDLE) && (state_next != IDLE)) begin
        sram_wdata <= mem_wdata;
        if (grant_owner == OWNER_MEM) begin
          sram_addr <= mem_addr;
          sram_we   <= mem_wr;
          sram_oe   <= ~mem_wr;
        end else begin
          sram_addr <= if_addr;
          sram_we   <= 1'b0;
          sram_oe   <= 1'b1;
        end
      end
      // A requester that let go mid-access still gets its data register refreshed, but no pulse
      if ((state == ACC_IF) && cnt_zero) begin
        if_rdata <= sram_rdata;
        if_ready <= if_req;
        sram_we  <= 1'b0;
        sram_oe  <= 1'b0;
      end
      if ((state == ACC_MEM) && cnt_zero) begin
        if (!sram_we) mem_rdata <= sram_rdata;
        mem_ready <= mem_req;
        sram_we   <= 1'b0;
        sram_oe   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed vector table, hand-written corner sequences and a
// randomized run compared against a timestamp-based model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int W  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic          if_req, mem_rd, mem_wr;
  logic [AW-1:0] if_addr, mem_addr, sram_addr;
  logic [DW-1:0] mem_wdata, if_rdata, mem_rdata, sram_wdata, sram_rdata;
  logic          if_ready, mem_ready, freeze_if, freeze_mem, sram_we, sram_oe;

  logic          b_if_req, b_mem_rd, b_mem_wr;
  logic [AW-1:0] b_if_addr, b_mem_addr, b_sram_addr;
  logic [DW-1:0] b_mem_wdata, b_if_rdata, b_mem_rdata, b_sram_wdata, b_sram_rdata;
  logic          b_if_ready, b_mem_ready, b_freeze_if, b_freeze_mem, b_sram_we, b_sram_oe;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .freeze_if(freeze_if), .freeze_mem(freeze_mem),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_we(sram_we), .sram_oe(sram_oe),
    .sram_rdata(sram_rdata)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
    .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .mem_ready(b_mem_ready),
    .freeze_if(b_freeze_if), .freeze_mem(b_freeze_mem),
    .sram_addr(b_sram_addr), .sram_wdata(b_sram_wdata), .sram_we(b_sram_we), .sram_oe(b_sram_oe),
    .sram_rdata(b_sram_rdata)
  );

  // Power-up SRAM contents, with the two words named in the test plan
  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h10)  return 32'hE3A01005;
    if (a == 32'h400) return 32'h0000002A;
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A0000;
  endfunction

  logic [31:0] sram_arr [0:1023];
  bit          sram_wr_flag [0:1023];

  always @(posedge clk) begin
    if (sram_we) begin
      sram_arr[sram_addr[11:2]]     <= sram_wdata;
      sram_wr_flag[sram_addr[11:2]] <= 1'b1;
    end
  end

  assign sram_rdata   = !sram_oe ? '0 :
                        (sram_wr_flag[sram_addr[11:2]] ? sram_arr[sram_addr[11:2]] : init_word(sram_addr));
  assign b_sram_rdata = b_sram_oe ? init_word(b_sram_addr) : '0;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // Reference memory for the randomized run
  logic [31:0] model_mem [int];
  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return init_word(a);
  endfunction

  typedef struct {
    string       name;
    bit          if_req;
    logic [31:0] if_addr;
    bit          mem_rd;
    bit          mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    int          exp_if_cyc;
    int          exp_mem_cyc;
    logic [31:0] exp_if_data;
    logic [31:0] exp_mem_data;
    logic [15:0] exp_we_mask;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int          if_cyc, mem_cyc, n_ifr, n_memr, bad;
    logic [31:0] if_d, mem_d;
    logic [15:0] we_mask;
    bit          if_on, mem_on;
    if_cyc = -1; mem_cyc = -1; n_ifr = 0; n_memr = 0; bad = 0;
    if_d = '0; mem_d = '0; we_mask = '0;
    if_on = v.if_req; mem_on = v.mem_rd | v.mem_wr;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if_req    = if_on;
      if_addr   = v.if_addr;
      mem_rd    = mem_on & v.mem_rd;
      mem_wr    = mem_on & v.mem_wr;
      mem_addr  = v.mem_addr;
      mem_wdata = v.mem_wdata;
      #1;
      if (freeze_if !== (if_req & ~if_ready)) bad++;
      if (freeze_mem !== ((mem_rd | mem_wr) & ~mem_ready)) bad++;
      if (sram_we) begin
        we_mask[c] = 1'b1;
        if (sram_addr !== v.mem_addr || sram_wdata !== v.mem_wdata) bad++;
      end
      if (if_ready) begin
        n_ifr++; if (if_cyc < 0) if_cyc = c; if_d = if_rdata; if_on = 1'b0;
      end
      if (mem_ready) begin
        n_memr++; if (mem_cyc < 0) mem_cyc = c; mem_d = mem_rdata; mem_on = 1'b0;
      end
    end
    check($sformatf("%s.if_ready_cycle", v.name), if_cyc, v.exp_if_cyc);
    check($sformatf("%s.mem_ready_cycle", v.name), mem_cyc, v.exp_mem_cyc);
    check($sformatf("%s.pulse_count", v.name), n_ifr + n_memr,
          (v.exp_if_cyc >= 0 ? 1 : 0) + (v.exp_mem_cyc >= 0 ? 1 : 0));
    if (v.exp_if_cyc >= 0)  check($sformatf("%s.if_rdata", v.name), if_d, v.exp_if_data);
    if (v.exp_mem_cyc >= 0) check($sformatf("%s.mem_rdata", v.name), mem_d, v.exp_mem_data);
    check($sformatf("%s.sram_we_cycles", v.name), we_mask, v.exp_we_mask);
    check($sformatf("%s.freeze_and_sram_stability", v.name), bad, 0);
  endtask

  vec_t vecs [6];

  initial begin
    int          pulses, cyc_q[$];
    logic [31:0] dat_q[$];
    int          free_at, ready_at, owner;
    logic [31:0] g_addr, g_wdata, exp_if_rdata, exp_mem_rdata;
    bit          g_write, if_pend, mem_pend, prev_ifr, prev_memr, exp_ifr, exp_memr;

    vecs[0] = '{"fetch",      1, 32'h10, 0, 0, 32'h0,   32'h0,        4, -1, 32'hE3A01005, 32'h0,        16'h0000};
    vecs[1] = '{"contention", 1, 32'h10, 1, 0, 32'h400, 32'h0,        9,  4, 32'hE3A01005, 32'h0000002A, 16'h0000};
    vecs[2] = '{"store",      0, 32'h0,  0, 1, 32'h404, 32'hDEADBEEF, -1, 4, 32'h0,        32'h0000002A, 16'h000E};
    vecs[3] = '{"load_back",  0, 32'h0,  1, 0, 32'h404, 32'h0,        -1, 4, 32'h0,        32'hDEADBEEF, 16'h0000};
    vecs[4] = '{"rd_wr_both", 0, 32'h0,  1, 1, 32'h408, 32'h12345678, -1, 4, 32'h0,        32'hDEADBEEF, 16'h000E};
    vecs[5] = '{"load_408",   0, 32'h0,  1, 0, 32'h408, 32'h0,        -1, 4, 32'h0,        32'h12345678, 16'h0000};

    rst = 1'b0;
    if_req = 0; if_addr = '0; mem_rd = 0; mem_wr = 0; mem_addr = '0; mem_wdata = '0;
    b_if_req = 0; b_if_addr = '0; b_mem_rd = 0; b_mem_wr = 0; b_mem_addr = '0; b_mem_wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("reset.ctrl", {sram_we, sram_oe, if_ready, mem_ready, freeze_if, freeze_mem}, 0);
    check("reset.sram_addr", sram_addr, 0);
    check("reset.sram_wdata", sram_wdata, 0);
    check("reset.if_rdata", if_rdata, 0);
    check("reset.mem_rdata", mem_rdata, 0);
    check("reset.w1_ctrl", {b_sram_we, b_sram_oe, b_if_ready, b_mem_ready, b_freeze_if, b_freeze_mem}, 0);
    check("reset.w1_data", b_if_rdata | b_mem_rdata | b_sram_wdata | b_sram_addr, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset asserted for two cycles in the middle of a store
    @(negedge clk);
    mem_wr = 1; mem_addr = 32'h40C; mem_wdata = 32'hCAFEF00D; if_req = 1; if_addr = 32'h20;
    @(negedge clk); #1;
    check("abort.store_started", sram_we, 1);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    check("abort.sram_ctrl", {sram_we, sram_oe}, 0);
    check("abort.sram_addr", sram_addr, 0);
    check("abort.rdata_cleared", if_rdata | mem_rdata, 0);
    check("abort.ready", {if_ready, mem_ready}, 0);
    pulses = 0;
    @(negedge clk); rst = 1'b1; mem_wr = 0; if_req = 0;
    for (int c = 0; c < 9; c++) begin
      #1;
      if (if_ready || mem_ready || sram_we || sram_oe) pulses++;
      @(negedge clk);
    end
    check("abort.no_activity_after", pulses, 0);

    // Fetch dropped at cycle 2: access completes silently, then IDLE at cycle 5
    pulses = 0;
    for (int c = 0; c < 14; c++) begin
      if (c == 0) begin if_req = 1; if_addr = 32'h20; end
      if (c == 2) if_req = 0;
      if (c == 5) begin mem_rd = 1; mem_addr = 32'h20; end
      #1;
      if (if_ready) pulses++;
      if (c == 5) check("drop.if_rdata_updated", if_rdata, init_word(32'h20));
      if (mem_ready) begin
        check("drop.next_grant_cycle", c, 9);
        check("drop.mem_rdata", mem_rdata, init_word(32'h20));
        mem_rd = 0;
      end
      @(negedge clk);
    end
    check("drop.no_if_ready", pulses, 0);
    check("drop.mem_released", mem_rd, 0);

    // WAIT_CYCLES=1 build: back-to-back fetches
    for (int c = 0; c < 11; c++) begin
      if (c == 0) begin b_if_req = 1; b_if_addr = 32'h0; end
      if (c == 3) b_if_addr = 32'h4;
      if (c == 6) b_if_req = 0;
      #1;
      if (b_if_ready) begin cyc_q.push_back(c); dat_q.push_back(b_if_rdata); end
      @(negedge clk);
    end
    check("w1.pulse_count", cyc_q.size(), 2);
    if (cyc_q.size() == 2) begin
      check("w1.first_ready_cycle", cyc_q[0], 2);
      check("w1.second_ready_cycle", cyc_q[1], 5);
      check("w1.first_data", dat_q[0], init_word(32'h0));
      check("w1.second_data", dat_q[1], init_word(32'h4));
    end

    // Randomized run against the arbitration-rule model
    repeat (3) @(negedge clk);
    free_at = 0; ready_at = -1; owner = 0;
    g_addr = '0; g_wdata = '0; g_write = 0;
    exp_if_rdata = if_rdata; exp_mem_rdata = init_word(32'h20);
    if_pend = 0; mem_pend = 0; prev_ifr = 0; prev_memr = 0;
    for (int c = 0; c < 600; c++) begin
      if (if_pend && prev_ifr)  if_pend = 0;
      if (mem_pend && prev_memr) mem_pend = 0;
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1; if_addr = 32'h800 + 32'($urandom_range(0, 15)) * 4;
      end
      if (!mem_pend && $urandom_range(0, 3) == 0) begin
        mem_pend  = 1;
        mem_addr  = 32'h800 + 32'($urandom_range(0, 15)) * 4;
        mem_wdata = $urandom;
        g_write   = ($urandom_range(0, 1) == 1);
        mem_wr    = g_write;
        mem_rd    = !g_write;
      end
      if_req = if_pend;
      if (!mem_pend) begin mem_rd = 0; mem_wr = 0; end
      #1;
      exp_ifr  = (owner == 2) && (c == ready_at);
      exp_memr = (owner == 1) && (c == ready_at);
      if (exp_ifr) exp_if_rdata = model_read(g_addr);
      if (exp_memr) begin
        if (g_write) model_mem[g_addr] = g_wdata;
        else         exp_mem_rdata = model_read(g_addr);
      end
      check($sformatf("rand[%0d].if_ready", c), if_ready, exp_ifr);
      check($sformatf("rand[%0d].mem_ready", c), mem_ready, exp_memr);
      check($sformatf("rand[%0d].freeze_if", c), freeze_if, if_req & ~exp_ifr);
      check($sformatf("rand[%0d].freeze_mem", c), freeze_mem, (mem_rd | mem_wr) & ~exp_memr);
      check($sformatf("rand[%0d].if_rdata", c), if_rdata, exp_if_rdata);
      check($sformatf("rand[%0d].mem_rdata", c), mem_rdata, exp_mem_rdata);
      if (c >= free_at && (mem_rd || mem_wr || if_req)) begin
        if (mem_rd || mem_wr) begin
          owner = 1; g_addr = mem_addr; g_wdata = mem_wdata; g_write = mem_wr;
        end else begin
          owner = 2; g_addr = if_addr;
        end
        ready_at = c + W + 1;
        free_at  = c + W + 2;
      end
      prev_ifr = if_ready; prev_memr = mem_ready;
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
